// File: rtl/ula_operand_seq.sv
// ============================================================================
// Module      : ula_operand_seq
// Description : Loads A, B and opcode from a shared valid/ready bus, drives
//               the ULA and holds its registered result until acknowledged.
//               Optional sticky overflow flag: define ULA_SEQ_OVF_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_operand_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     dado_in,
    input  logic             dado_valido,
    output logic             dado_pronto,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic [1:0]       op_f,
    input  logic [W-1:0]     ula_saida,
    input  logic             ula_flag,
    output logic [W-1:0]     resultado,
    output logic             flag_ovf,
    output logic             res_valido,
    input  logic             res_ack,
    output logic [CNT_W-1:0] n_ops,
    output logic             ovf_sticky
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        ESPERA_F  = 3'd2,
        EXECUTA   = 3'd3,
        RESULTADO = 3'd4
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic [1:0]       r_op_f;
    logic [W-1:0]     r_resultado;
    logic             r_flag_ovf;
    logic             r_res_valido;
    logic [CNT_W-1:0] r_n_ops;
    logic             w_espera;
    logic             w_xfer;

    assign w_espera = (r_state == ESPERA_A) || (r_state == ESPERA_B) ||
                      (r_state == ESPERA_F);
    // Gated by reset so the bus is refused while reset is held.
    assign dado_pronto = w_espera && !reset;
    assign w_xfer      = dado_valido && dado_pronto;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ESPERA_A;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_f       <= '0;
            r_resultado  <= '0;
            r_flag_ovf   <= 1'b0;
            r_res_valido <= 1'b0;
            r_n_ops      <= '0;
        end else begin
            case (r_state)
                ESPERA_A: begin
                    if (w_xfer) begin
                        r_op_a  <= dado_in;
                        r_state <= ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (w_xfer) begin
                        r_op_b  <= dado_in;
                        r_state <= ESPERA_F;
                    end
                end
                ESPERA_F: begin
                    if (w_xfer) begin
                        r_op_f  <= dado_in[1:0];
                        r_state <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    // Operands have been stable for a full cycle; capture the ULA.
                    r_resultado  <= ula_saida;
                    r_flag_ovf   <= ula_flag;
                    r_res_valido <= 1'b1;
                    r_state      <= RESULTADO;
                end
                RESULTADO: begin
                    if (res_ack) begin
                        r_res_valido <= 1'b0;
                        r_n_ops      <= r_n_ops + c_cnt_one;
                        r_state      <= ESPERA_A;
                    end
                end
                default: r_state <= ESPERA_A;
            endcase
        end
    end

    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign op_f       = r_op_f;
    assign resultado  = r_resultado;
    assign flag_ovf   = r_flag_ovf;
    assign res_valido = r_res_valido;
    assign n_ops      = r_n_ops;

`ifdef ULA_SEQ_OVF_STICKY_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if ((r_state == EXECUTA) && ula_flag) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/ula_operand_seq.md
Name: ula_operand_seq

Overview:
- Upstream sequencer for the 8-bit signed ULA (AND/OR/ADD/SUB, overflow flag).
- Loads operand A, operand B and the 2-bit opcode, in that order, from one shared 8-bit input bus using a valid/ready handshake.
- Drives the operands and opcode to the ULA, registers the ULA result and overflow flag, and holds them until the consumer acknowledges.
- Counts completed operations.

Parameters:
- W, 8, data width of the bus, operands and result.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dado_in  input  W  shared load bus. A and B are taken signed; for the opcode only bits [1:0] are used.
- dado_valido  input  1  dado_in is valid this cycle.
- dado_pronto  output  1  block accepts dado_in this cycle.
- op_a  output  W  registered operand A to the ULA (signed).
- op_b  output  W  registered operand B to the ULA (signed).
- op_f  output  2  registered opcode to the ULA (00 AND, 01 OR, 10 ADD, 11 SUB).
- ula_saida  input  W  combinational ULA result.
- ula_flag  input  1  combinational ULA overflow flag.
- resultado  output  W  registered result.
- flag_ovf  output  1  registered overflow flag for this result.
- res_valido  output  1  resultado/flag_ovf are valid.
- res_ack  input  1  consumer takes the result.
- n_ops  output  CNT_W  count of acknowledged results.
- ovf_sticky  output  1  sticky overflow indicator (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state ESPERA_A; dado_pronto 0 while reset is asserted.
- Transfer rule: a load happens only on a cycle where dado_valido && dado_pronto.
- dado_pronto = 1 exactly in ESPERA_A, ESPERA_B and ESPERA_F (Moore output, decoded from state).
- ESPERA_A: on transfer, op_a <= dado_in; go to ESPERA_B. Otherwise hold.
- ESPERA_B: on transfer, op_b <= dado_in; go to ESPERA_F.
- ESPERA_F: on transfer, op_f <= dado_in[1:0]; go to EXECUTA. dado_in[W-1:2] are ignored.
- EXECUTA: one cycle; op_a/op_b/op_f are stable and the ULA settles. On the exit edge: resultado <= ula_saida, flag_ovf <= ula_flag, res_valido <= 1; go to RESULTADO.
- RESULTADO: hold resultado, flag_ovf and res_valido steady.
  - On res_ack: res_valido <= 0; n_ops <= n_ops + 1 (wraps from 2^CNT_W-1 to 0); go to ESPERA_A.
  - The next A can be accepted on the following cycle.
- Latency: result is valid 2 cycles after the opcode transfer edge (EXECUTA cycle, then the registering edge).
- Throughput: 1 operation per at least 5 cycles.
- op_a, op_b and op_f keep their last values after an operation until overwritten by a new load.
- res_ack outside RESULTADO: ignored.
- dado_valido in EXECUTA or RESULTADO: ignored; no data is lost because dado_pronto = 0 in those states.
- res_ack held high continuously: each result lives at least 1 cycle in RESULTADO; n_ops increments once per result.
- Reset mid-operation (any state): immediately returns to ESPERA_A with all outputs 0. A partial load is discarded; n_ops clears.
- No arithmetic is done in this block. Width and sign semantics are those of the ULA (two's-complement wrap, flag from the ULA).

Optional Feature:
- Macro: ULA_SEQ_OVF_STICKY_EN.
- With the macro defined:
  - ovf_sticky <= 1 on the EXECUTA exit edge if ula_flag = 1.
  - It stays 1 across later operations; only reset clears it.
- Without the macro:
  - ovf_sticky is tied to 0 and no register is inferred.
  - The port still exists, so the interface is identical in both builds.

Test Plan:
- After reset, load A=100, B=50, F=2 (ADD) -> 2 cycles later resultado=-106 (0x96), flag_ovf=1, res_valido=1. On res_ack, n_ops=1 and dado_pronto=1 on the next cycle.
- Load A=-100, B=50, F=3 (SUB) -> resultado=106 (0x6A), flag_ovf=1. Load A=0x0F, B=0x3C, F=0 (AND) -> resultado=0x0C, flag_ovf=0. Repeat with F=1 (OR) -> resultado=0x3F, flag_ovf=0.
- Toggle dado_valido with gaps between A, B and F; assert dado_valido in EXECUTA/RESULTADO with garbage data -> op_a/op_b/op_f are unchanged by the garbage; result is correct; dado_pronto=0 in those states.
- Hold res_ack=0 for 10 cycles in RESULTADO -> result is stable and res_valido stays 1. Then run 256 acknowledged operations with CNT_W=8 -> n_ops wraps to 0.
- Assert reset after B is loaded, in ESPERA_F -> all outputs 0 and state ESPERA_A. The next full sequence 5, 3, ADD gives resultado=8.
- With ULA_SEQ_OVF_STICKY_EN defined: run overflow ADD (100+50), then AND (0x0F & 0x3C) -> ovf_sticky=1 after both; reset clears it. Without the macro, ovf_sticky=0 throughout.
